multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 arst_n  in  1  asynchronous active-low reset.
REQ-005 opcode  in  7  RISC-V opcode[6:0] from instruction register; valid from DECODE onward.
REQ-006 mem_ready  in  1  memory completes current read/write this cycle.
REQ-007 pc_write  out  1  unconditional PC update.
REQ-008 pc_write_cond  out  1  PC update qualified by datapath ALU zero.
REQ-009 pc_source  out  1  0 = ALU result, 1 = ALUOut register.
REQ-010 ir_write  out  1  load instruction register.
REQ-011 mem_read, mem_write  out  1 each  memory strobes, held until mem_ready.
REQ-012 mem_2_reg  out  1  write-back selects memory data.
REQ-013 alu_src_a  out  1  0 = PC, 1 = rs1.
REQ-014 alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
REQ-015 alu_op  out  2  00 ADD, 01 SUB, 10 R-type.
REQ-016 reg_write  out  1  register-file write enable.
REQ-017 illegal_op  out  1  sticky unsupported-opcode flag.
REQ-018 instr_done  out  1  one-cycle pulse on instruction retire.
REQ-019 retired_cnt  out  CNT_W  retired-instruction count.

Function
REQ-020 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; outputs are Moore-style from state and latched opcode.
REQ-021 Unlisted control outputs SHALL be 0 in each state; alu_op defaults to ADD.
REQ-022 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01; stays in FETCH while mem_ready=0; on mem_ready=1 asserts ir_write=1, pc_write=1, pc_source=0 that cycle -> DECODE.
REQ-023 DECODE: opcode latched into internal register; alu_src_a=0, alu_src_b=10 (target into ALUOut); supported opcode -> EXEC, otherwise -> TRAP.
REQ-024 Supported opcodes: 0110011 R, 0010011 I, 1100011 BEQ, 1101111 JAL, 0000011 LOAD, 0100011 STORE.
REQ-025 EXEC R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB.
REQ-026 EXEC I: alu_src_a=1, alu_src_b=10, alu_op=00 -> WB.
REQ-027 EXEC LOAD/STORE: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM.
REQ-028 EXEC BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, instr_done=1 -> FETCH.
REQ-029 EXEC JAL: pc_write=1, pc_source=1, instr_done=1 -> FETCH.
REQ-030 MEM LOAD: mem_read=1 until mem_ready -> WB; MEM STORE: mem_write=1 until mem_ready, then instr_done=1 -> FETCH.
REQ-031 WB: reg_write=1, mem_2_reg=1 for LOAD else 0, instr_done=1 -> FETCH.
REQ-032 TRAP: illegal_op=1, all other outputs 0, no exit except reset.
REQ-033 Zero-wait latencies SHALL be: BEQ/JAL 3, STORE/R/I 4, LOAD 5 cycles; each mem_ready=0 cycle adds one.
REQ-034 retired_cnt SHALL increment by 1 on every instr_done cycle, wrapping 2^CNT_W-1 -> 0.
REQ-035 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-036 opcode changes after DECODE SHALL not affect the current instruction.

Reset
REQ-037 arst_n low SHALL force FETCH, latched opcode 0, illegal_op 0, retired_cnt 0, and all outputs to their FETCH-state values asynchronously.
REQ-038 Reset mid-MEM SHALL drop mem_read/mem_write immediately; no instr_done or count for the aborted instruction.

Structure
REQ-039 Opcode constants, alu_op codes, alu_src_b codes and state enumeration SHALL live in the shared package.
REQ-040 The retire counter SHALL be a separate sub-module, retire_counter (parameter CNT_W, inputs clk, arst_n, inc).

Verification
REQ-041 R-type 0110011, mem_ready=1 -> states FETCH,DECODE,EXEC,WB; reg_write=1 in cycle 4 only; retired_cnt 0->1.
REQ-042 LOAD with mem_ready=0 for 2 MEM cycles -> mem_read held 3 cycles; WB with mem_2_reg=1; total 7 cycles.
REQ-043 BEQ -> cycle 3 pc_write_cond=1, pc_source=1, alu_op=01; reg_write never 1.
REQ-044 Opcode 1111111 -> TRAP after DECODE; illegal_op=1 held 20 cycles; retired_cnt unchanged.
REQ-045 arst_n low during STORE MEM -> mem_write 0 same cycle; after release FETCH with mem_read=1, retired_cnt=0.
REQ-046 CNT_W=4, 16 R-type instructions -> retired_cnt wraps 15 -> 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: FSM states,
// supported opcodes and the ALU operand/operation select codes.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    // Supported RISC-V major opcodes (instruction bits [6:0]).
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // alu_op codes.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    // alu_src_b codes.
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // True for every opcode this controller knows how to sequence.
    function automatic logic is_supported(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_BEQ, OP_JAL, OP_LOAD, OP_STORE: is_supported = 1'b1;
            default:                                       is_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Free-running count of retired instructions; wraps at 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one per retire pulse; natural overflow gives the wrap to zero.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle RISC-V datapath. Outputs come
// from the current state and the opcode latched in DECODE; only the memory
// handshake (mem_ready) qualifies outputs within FETCH and MEM.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_2_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t     state;
    state_t     state_next;
    logic [6:0] op_q;

    // State register; reset lands in FETCH so outputs show fetch values at once.
    // NOTE: only control registers get the async reset; every output here is
    // decoded from state, so resetting state alone drops memory strobes
    // immediately without needing to reset any datapath storage.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Capture the opcode in DECODE so later instruction-register changes are ignored.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            op_q <= '0;
        end else if (state == DECODE) begin
            op_q <= opcode;
        end
    end

    // Next-state and control-output decode.
    // NOTE: every output gets a default before the case statement so that no
    // path through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_2_reg     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;

        case (state)
            FETCH: begin
                // PC + 4 computed while the instruction read is outstanding.
                mem_read  = 1'b1;
                alu_src_a = 1'b0;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    pc_source  = 1'b0;
                    state_next = DECODE;
                end
            end

            DECODE: begin
                // Branch/jump target PC + imm goes into ALUOut for use in EXEC.
                alu_src_a  = 1'b0;
                alu_src_b  = SRC_B_IMM;
                state_next = is_supported(opcode) ? EXEC : TRAP;
            end

            EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_src_a  = 1'b1;
                        alu_src_b  = SRC_B_RS2;
                        alu_op     = ALU_RTYPE;
                        state_next = WB;
                    end
                    OP_I: begin
                        alu_src_a  = 1'b1;
                        alu_src_b  = SRC_B_IMM;
                        alu_op     = ALU_ADD;
                        state_next = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a  = 1'b1;
                        alu_src_b  = SRC_B_IMM;
                        alu_op     = ALU_ADD;
                        state_next = MEM;
                    end
                    OP_BEQ: begin
                        alu_src_a     = 1'b1;
                        alu_src_b     = SRC_B_RS2;
                        alu_op        = ALU_SUB;
                        pc_write_cond = 1'b1;
                        pc_source     = 1'b1;
                        instr_done    = 1'b1;
                        state_next    = FETCH;
                    end
                    OP_JAL: begin
                        pc_write   = 1'b1;
                        pc_source  = 1'b1;
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end
                    default: begin
                        // Unreachable: DECODE only admits supported opcodes.
                        state_next = TRAP;
                    end
                endcase
            end

            MEM: begin
                if (op_q == OP_LOAD) begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_next = WB;
                    end
                end else begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end
                end
            end

            WB: begin
                reg_write  = 1'b1;
                mem_2_reg  = (op_q == OP_LOAD);
                instr_done = 1'b1;
                state_next = FETCH;
            end

            TRAP: begin
                // Absorbing state; only reset leaves it, which makes the flag sticky.
                illegal_op = 1'b1;
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (instr_done),
        .count  (retired_cnt)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control. Each instruction is expanded into
// its expected per-cycle control vectors from the instruction class and the
// memory wait counts; a 32-bit and a 4-bit counter instance share stimulus.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_2_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       illegal_op;
        logic       instr_done;
    } ctl_t;

    typedef struct {
        string      tag;
        logic       rdy;
        logic [6:0] op;
        ctl_t       exp;
    } step_t;

    localparam logic [6:0] T_R     = 7'b0110011;
    localparam logic [6:0] T_I     = 7'b0010011;
    localparam logic [6:0] T_BEQ   = 7'b1100011;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;

    logic        clk;
    logic        arst_n;
    logic [6:0]  opcode;
    logic        mem_ready;

    logic        pc_write, pc_write_cond, pc_source, ir_write, mem_read, mem_write;
    logic        mem_2_reg, alu_src_a, reg_write, illegal_op, instr_done;
    logic [1:0]  alu_src_b, alu_op;
    logic [31:0] retired_cnt;

    logic        pc_write4, pc_write_cond4, pc_source4, ir_write4, mem_read4, mem_write4;
    logic        mem_2_reg4, alu_src_a4, reg_write4, illegal_op4, instr_done4;
    logic [1:0]  alu_src_b4, alu_op4;
    logic [3:0]  retired_cnt4;

    ctl_t        got, got4;
    step_t       plan[$];
    logic [31:0] exp_cnt;
    int          n_checks;
    int          n_errors;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .arst_n(arst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_2_reg(mem_2_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .illegal_op(illegal_op),
        .instr_done(instr_done), .retired_cnt(retired_cnt)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .arst_n(arst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .pc_source(pc_source4),
        .ir_write(ir_write4), .mem_read(mem_read4), .mem_write(mem_write4),
        .mem_2_reg(mem_2_reg4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
        .alu_op(alu_op4), .reg_write(reg_write4), .illegal_op(illegal_op4),
        .instr_done(instr_done4), .retired_cnt(retired_cnt4)
    );

    assign got  = ctl_t'({pc_write, pc_write_cond, pc_source, ir_write, mem_read, mem_write,
                          mem_2_reg, alu_src_a, alu_src_b, alu_op, reg_write, illegal_op,
                          instr_done});
    assign got4 = ctl_t'({pc_write4, pc_write_cond4, pc_source4, ir_write4, mem_read4,
                          mem_write4, mem_2_reg4, alu_src_a4, alu_src_b4, alu_op4,
                          reg_write4, illegal_op4, instr_done4});

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    task automatic push(input string tag, input logic rdy, input logic [6:0] op, input ctl_t e);
        step_t s;
        s.tag = tag;
        s.rdy = rdy;
        s.op  = op;
        s.exp = e;
        plan.push_back(s);
    endtask

    // Instruction fetch with fw wait cycles, then the decode cycle for op.
    task automatic add_front(input logic [6:0] op, input int fw);
        ctl_t e;
        e = '0;
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'b01;
        for (int i = 0; i < fw; i++) push("fetch_wait", 1'b0, rnd_op(), e);
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        push("fetch", 1'b1, rnd_op(), e);
        e = '0;
        e.alu_src_b = 2'b10;
        push("decode", rnd_bit(), op, e);
    endtask

    task automatic add_wb(input logic is_load);
        ctl_t e;
        e = '0;
        e.reg_write  = 1'b1;
        e.mem_2_reg  = is_load;
        e.instr_done = 1'b1;
        push("wb", rnd_bit(), rnd_op(), e);
    endtask

    // Full expected cycle sequence of one supported instruction.
    task automatic add_instr(input logic [6:0] op, input int fw, input int mw);
        ctl_t e;
        add_front(op, fw);
        e = '0;
        case (op)
            T_R: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 2'b10;
                push("exec_r", rnd_bit(), rnd_op(), e);
                add_wb(1'b0);
            end
            T_I: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b00;
                push("exec_i", rnd_bit(), rnd_op(), e);
                add_wb(1'b0);
            end
            T_BEQ: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 2'b01;
                e.pc_write_cond = 1'b1; e.pc_source = 1'b1; e.instr_done = 1'b1;
                push("exec_beq", rnd_bit(), rnd_op(), e);
            end
            T_JAL: begin
                e.pc_write = 1'b1; e.pc_source = 1'b1; e.instr_done = 1'b1;
                push("exec_jal", rnd_bit(), rnd_op(), e);
            end
            default: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b00;
                push("exec_mem", rnd_bit(), rnd_op(), e);
                e = '0;
                if (op == T_LOAD) begin
                    e.mem_read = 1'b1;
                    for (int i = 0; i < mw; i++) push("mem_ld_wait", 1'b0, rnd_op(), e);
                    push("mem_ld", 1'b1, rnd_op(), e);
                    add_wb(1'b1);
                end else begin
                    e.mem_write = 1'b1;
                    for (int i = 0; i < mw; i++) push("mem_st_wait", 1'b0, rnd_op(), e);
                    e.instr_done = 1'b1;
                    push("mem_st", 1'b1, rnd_op(), e);
                end
            end
        endcase
    endtask

    // Consume up to n planned cycles, comparing every output each cycle.
    task automatic run_plan(input int n);
        step_t s;
        for (int i = 0; i < n && plan.size() > 0; i++) begin
            s = plan.pop_front();
            @(negedge clk);
            mem_ready = s.rdy;
            opcode    = s.op;
            #1;
            check(s.tag, 64'(got), 64'(s.exp));
            check({s.tag, "_cnt"}, 64'(retired_cnt), 64'(exp_cnt));
            check({s.tag, "_w4"}, 64'(got4), 64'(s.exp));
            check({s.tag, "_cnt4"}, 64'(retired_cnt4), 64'(exp_cnt[3:0]));
            if (s.exp.instr_done) exp_cnt = exp_cnt + 32'd1;
        end
    endtask

    initial begin
        logic [6:0] ops [6];
        ctl_t       e;
        ops = '{T_R, T_I, T_BEQ, T_JAL, T_LOAD, T_STORE};
        n_checks  = 0;
        n_errors  = 0;
        exp_cnt   = '0;
        mem_ready = 1'b0;
        opcode    = '0;
        arst_n    = 1'b1;

        // Reset state: FETCH outputs with no memory response yet.
        #1 arst_n = 1'b0;
        #2;
        e = '0;
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'b01;
        check("reset_ctl", 64'(got), 64'(e));
        check("reset_cnt", 64'(retired_cnt), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        // Directed: R, LOAD with two MEM waits, BEQ, STORE, JAL, I.
        add_instr(T_R, 0, 0);
        add_instr(T_LOAD, 0, 2);
        add_instr(T_BEQ, 0, 0);
        add_instr(T_STORE, 1, 1);
        add_instr(T_JAL, 0, 0);
        add_instr(T_I, 2, 0);
        run_plan(1000);

        // Randomized instruction mix and wait states.
        for (int k = 0; k < 50; k++) begin
            add_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3));
        end
        run_plan(100000);

        // Reset while a STORE waits in MEM: the write strobe must drop at once.
        add_instr(T_STORE, 0, 5);
        run_plan(4);
        #2 arst_n = 1'b0;
        #1;
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_mem_read", 64'(mem_read), 64'd1);
        check("rst_src_b", 64'(alu_src_b), 64'd1);
        check("rst_done", 64'(instr_done), 64'd0);
        check("rst_cnt", 64'(retired_cnt), 64'd0);
        plan.delete();
        exp_cnt = '0;
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        check("post_rst_mem_read", 64'(mem_read), 64'd1);
        check("post_rst_cnt", 64'(retired_cnt), 64'd0);

        // Sixteen R-type instructions: the 4-bit counter wraps 15 -> 0.
        for (int k = 0; k < 16; k++) add_instr(T_R, 0, 0);
        run_plan(1000);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("wrap_cnt4", 64'(retired_cnt4), 64'd0);
        check("cnt16", 64'(retired_cnt), 64'd16);

        // Unsupported opcode: TRAP after DECODE, flag held, count frozen.
        add_front(7'b1111111, 0);
        e = '0;
        e.illegal_op = 1'b1;
        for (int k = 0; k < 20; k++) push("trap", rnd_bit(), rnd_op(), e);
        run_plan(1000);
        check("trap_cnt", 64'(retired_cnt), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
